// File: rtl/qtr_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : qtr_emu_if
// Brief    : Peripheral daisy-chain bus bundle for the QTR-RC sensor emulator.
// Revision : 1.0
// ============================================================================
interface qtr_emu_if;
    logic        rdwr;
    logic        strobe;
    logic [3:0]  our_addr;
    logic [11:0] addr;
    logic        busy_in;
    logic        busy_out;
    logic        addr_match_in;
    logic        addr_match_out;
    logic [7:0]  datin;
    logic [7:0]  datout;

    modport master (
        output rdwr, strobe, our_addr, addr, busy_in, addr_match_in, datin,
        input  busy_out, addr_match_out, datout
    );

    modport slave (
        input  rdwr, strobe, our_addr, addr, busy_in, addr_match_in, datin,
        output busy_out, addr_match_out, datout
    );
endinterface
`default_nettype wire

// File: rtl/qtr_emu.sv
`default_nettype none
// ============================================================================
// Module   : qtr_emu
// Brief    : Eight-channel Pololu QTR-RC reflectance sensor emulator.
//            Optional reg 10 channel-0 edge counter: QTR_EMU_TRIGCNT_EN.
// Revision : 1.0
// ============================================================================
module qtr_emu (
    input  wire logic       clk,
    input  wire logic       reset,
    qtr_emu_if.slave        bus,
    input  wire logic       u10clk,
    input  wire logic [7:0] q_in,
    output logic      [7:0] q_oe,
    output logic      [7:0] q_out
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_LOW   = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    localparam logic [3:0] c_IDX_MASK    = 4'd8;
    localparam logic [3:0] c_IDX_FLAGS   = 4'd9;
    localparam logic [3:0] c_IDX_TRIGCNT = 4'd10;

    logic        w_myaddr;
    logic        w_wr;
    logic        w_rd;
    logic [3:0]  w_idx;
    logic [7:0]  w_rdata;
    logic [7:0]  w_trig_rdata;

    logic [7:0]  r_sync_m;
    logic [7:0]  r_sync_s1;
    logic [7:0]  r_sync_s2;
    logic [7:0]  w_rise;

    logic [7:0]  r_decay [8];
    logic [7:0]  r_mask;
    logic [7:0]  r_flags;
    logic [7:0]  w_flag_set;

    assign w_myaddr = (bus.addr[11:8] == bus.our_addr) && (bus.addr[7:4] == 4'd0);
    assign w_idx    = bus.addr[3:0];
    assign w_wr     = bus.strobe & w_myaddr & ~bus.rdwr;
    assign w_rd     = bus.strobe & w_myaddr &  bus.rdwr;

    assign bus.busy_out       = bus.busy_in;
    assign bus.addr_match_out = w_myaddr | bus.addr_match_in;
    assign bus.datout         = w_rd ? w_rdata : bus.datin;
    assign q_out              = 8'h00;

    // r_sync_s2 is only the edge-detect delay behind the two-flop synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_m  <= 8'h00;
            r_sync_s1 <= 8'h00;
            r_sync_s2 <= 8'h00;
        end else begin
            r_sync_m  <= q_in;
            r_sync_s1 <= r_sync_m;
            r_sync_s2 <= r_sync_s1;
        end
    end

    assign w_rise = r_sync_s1 & ~r_sync_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_decay[i] <= 8'h00;
            end
            r_mask  <= 8'h00;
            r_flags <= 8'h00;
        end else begin
            if (w_wr && !w_idx[3]) begin
                r_decay[w_idx[2:0]] <= bus.datin;
            end
            if (w_wr && (w_idx == c_IDX_MASK)) begin
                r_mask <= bus.datin;
            end
            // A same-clock edge survives the read-clear.
            r_flags <= ((w_rd && (w_idx == c_IDX_FLAGS)) ? 8'h00 : r_flags) | w_flag_set;
        end
    end

`ifdef QTR_EMU_TRIGCNT_EN
    logic [7:0] r_trig_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_cnt <= 8'h00;
        end else begin
            r_trig_cnt <= ((w_rd && (w_idx == c_IDX_TRIGCNT)) ? 8'h00 : r_trig_cnt)
                          + {7'd0, w_rise[0]};
        end
    end

    assign w_trig_rdata = r_trig_cnt;
`else
    assign w_trig_rdata = 8'h00;
`endif

    always_comb begin
        w_rdata = 8'h00;
        if (!w_idx[3]) begin
            w_rdata = r_decay[w_idx[2:0]];
        end else if (w_idx == c_IDX_MASK) begin
            w_rdata = r_mask;
        end else if (w_idx == c_IDX_FLAGS) begin
            w_rdata = r_flags;
        end else if (w_idx == c_IDX_TRIGCNT) begin
            w_rdata = w_trig_rdata;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        state_t     r_state;
        state_t     w_state_nxt;
        logic [7:0] r_d;
        logic [7:0] r_cnt;
        logic [7:0] w_d_nxt;
        logic [7:0] w_cnt_nxt;
        logic       w_set;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_OFF;
                r_d     <= 8'h00;
                r_cnt   <= 8'h00;
            end else begin
                r_state <= w_state_nxt;
                r_d     <= w_d_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Decay length is latched at the trigger so mid-cycle writes wait for the next edge.
        always_comb begin
            w_state_nxt = r_state;
            w_d_nxt     = r_d;
            w_cnt_nxt   = r_cnt;
            w_set       = 1'b0;
            if (!r_mask[gi]) begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = 8'h00;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        w_state_nxt = ST_LOW;
                    end
                    ST_LOW, ST_DECAY: begin
                        if (w_rise[gi]) begin
                            w_set     = 1'b1;
                            w_d_nxt   = r_decay[gi];
                            w_cnt_nxt = 8'h00;
                            if (r_decay[gi] == 8'h00) begin
                                w_state_nxt = ST_LOW;
                            end else begin
                                w_state_nxt = ST_DECAY;
                            end
                        end else if ((r_state == ST_DECAY) && u10clk) begin
                            w_cnt_nxt = r_cnt + 8'd1;
                            if ((r_cnt + 8'd1) == r_d) begin
                                w_state_nxt = ST_LOW;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_OFF;
                    end
                endcase
            end
        end

        assign w_flag_set[gi] = w_set;
        assign q_oe[gi]       = (r_state == ST_LOW);
    end
endmodule
`default_nettype wire

// File: tb/tb_qtr_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtr_emu
// Brief    : Self-checking bench for qtr_emu: vector table, directed corner
//            sequences and random traffic against a behavioural channel model.
// Revision : 1.0
// ============================================================================
module tb_qtr_emu;
    localparam logic [3:0]  c_OUR  = 4'hA;
    localparam logic [11:0] c_BASE = 12'hA00;
`ifdef QTR_EMU_TRIGCNT_EN
    localparam logic [7:0]  c_EXP_CNT257 = 8'd1;
`else
    localparam logic [7:0]  c_EXP_CNT257 = 8'd0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       u10clk = 1'b0;
    logic [7:0] q_in   = 8'h00;
    logic [7:0] q_oe;
    logic [7:0] q_out;

    qtr_emu_if bus ();

    qtr_emu dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .u10clk (u10clk),
        .q_in   (q_in),
        .q_oe   (q_oe),
        .q_out  (q_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus applied on the next cycle
    logic [7:0]  cur_q    = 8'h00;
    logic        cur_u    = 1'b0;
    logic        cur_strb = 1'b0;
    logic        cur_rw   = 1'b0;
    logic [11:0] cur_addr = 12'h000;
    logic [7:0]  cur_din  = 8'h00;
    logic        cur_busy = 1'b0;
    logic        cur_am   = 1'b0;
    logic [7:0]  last_dout;

    // Behavioural model: a channel is "on" when enabled and owes m_rem more
    // 10us ticks before it pulls low again.
    logic [7:0] m_decay [8];
    logic [7:0] m_mask, m_flags, m_cnt;
    logic       m_on [8];
    int         m_rem [8];
    logic [7:0] h1, h2, h3;

    typedef struct {
        logic        strb;
        logic        rw;
        logic [11:0] addr;
        logic [7:0]  din;
        logic        busy;
        logic        am;
        logic [7:0]  exp_dout;
        logic        exp_busy;
        logic        exp_am;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input int n, input logic exp);
        chk(name, 16'(q_oe[n]), 16'(exp));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_decay[i] = 8'h00;
            m_on[i]    = 1'b0;
            m_rem[i]   = 0;
        end
        m_mask = 8'h00; m_flags = 8'h00; m_cnt = 8'h00;
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] idx);
        if (idx < 4'd8) return m_decay[idx[2:0]];
        if (idx == 4'd8) return m_mask;
        if (idx == 4'd9) return m_flags;
`ifdef QTR_EMU_TRIGCNT_EN
        if (idx == 4'd10) return m_cnt;
`endif
        return 8'h00;
    endfunction

    function automatic logic [7:0] model_qoe();
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = m_on[n] && (m_rem[n] == 0);
        return r;
    endfunction

    function automatic logic is_mine(input logic [11:0] a);
        return (a[11:8] == c_OUR) && (a[7:4] == 4'd0);
    endfunction

    // One clock of behaviour, evaluated with the stimulus present at this edge.
    task automatic model_update();
        logic [7:0] rise, setf;
        logic       rd, wr;
        logic [3:0] idx;
        idx  = cur_addr[3:0];
        rd   = cur_strb & is_mine(cur_addr) & cur_rw;
        wr   = cur_strb & is_mine(cur_addr) & ~cur_rw;
        rise = h2 & ~h3;
        setf = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (!m_mask[n]) begin
                m_on[n] = 1'b0;
            end else if (!m_on[n]) begin
                m_on[n]  = 1'b1;
                m_rem[n] = 0;
            end else if (rise[n]) begin
                setf[n]  = 1'b1;
                m_rem[n] = int'(m_decay[n]);
            end else if (cur_u && m_rem[n] > 0) begin
                m_rem[n] = m_rem[n] - 1;
            end
        end
        m_flags = ((rd && idx == 4'd9) ? 8'h00 : m_flags) | setf;
        m_cnt   = ((rd && idx == 4'd10) ? 8'h00 : m_cnt) + {7'd0, rise[0]};
        if (wr && idx < 4'd8) m_decay[idx[2:0]] = cur_din;
        if (wr && idx == 4'd8) m_mask = cur_din;
        h3 = h2; h2 = h1; h1 = cur_q;
    endtask

    task automatic cyc();
        logic       mine, rd;
        logic [7:0] exp_d;
        @(negedge clk);
        q_in              = cur_q;
        u10clk            = cur_u;
        bus.strobe        = cur_strb;
        bus.rdwr          = cur_rw;
        bus.addr          = cur_addr;
        bus.datin         = cur_din;
        bus.busy_in       = cur_busy;
        bus.addr_match_in = cur_am;
        #1;
        mine      = is_mine(cur_addr);
        rd        = cur_strb & mine & cur_rw;
        exp_d     = rd ? model_read(cur_addr[3:0]) : cur_din;
        last_dout = bus.datout;
        chk("bus_out", 16'({bus.datout, bus.busy_out, bus.addr_match_out}),
            16'({exp_d, cur_busy, mine | cur_am}));
        @(posedge clk);
        model_update();
        #1;
        chk("q_oe_model", 16'(q_oe), 16'(model_qoe()));
    endtask

    task automatic idle(input int n);
        cur_strb = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic pulse();
        cur_u = 1'b1; cyc(); cur_u = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] val);
        cur_strb = 1'b1; cur_rw = 1'b0; cur_addr = c_BASE | 12'(idx); cur_din = val;
        cyc();
        cur_strb = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [7:0] exp, input string name);
        cur_strb = 1'b1; cur_rw = 1'b1; cur_addr = c_BASE | 12'(idx); cur_din = 8'hEE;
        cyc();
        cur_strb = 1'b0;
        chk(name, 16'(last_dout), 16'(exp));
    endtask

    task automatic edge_on(input int n, input int hold);
        cur_q[n] = 1'b1;
        repeat (hold) cyc();
        cur_q[n] = 1'b0;
        repeat (2) cyc();
    endtask

    // Asserted between clock edges so the output clear is visibly asynchronous.
    task automatic do_reset();
        cur_q = 8'h00; cur_u = 1'b0; cur_strb = 1'b0;
        q_in = 8'h00; u10clk = 1'b0; bus.strobe = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_q_oe", 16'(q_oe), 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.our_addr = c_OUR; bus.rdwr = 1'b0; bus.strobe = 1'b0; bus.addr = 12'h000;
        bus.datin = 8'h00; bus.busy_in = 1'b0; bus.addr_match_in = 1'b0;

        //               strb rw  addr     din    busy am   exp_d  eb    eam
        tbl[0]  = '{1'b0, 1'b1, 12'hA03, 8'h33, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 12'hA03, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 12'hB03, 8'h44, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 12'hB03, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 12'hA13, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 12'hA08, 8'h00, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 12'hA0F, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 12'hA0B, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 12'hA0A, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 12'hA03, 8'h77, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 12'hA03, 8'h00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 12'hA09, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        do_reset();
        chk("q_out_const", 16'(q_out), 16'h0000);
        rd(4'd8, 8'h00, "reset_mask");

        // Bus decode and register map
        wr(4'd3, 8'h5A);
        wr(4'd8, 8'hC3);
        for (int i = 0; i < 12; i++) begin
            cur_strb = tbl[i].strb; cur_rw = tbl[i].rw; cur_addr = tbl[i].addr;
            cur_din  = tbl[i].din;  cur_busy = tbl[i].busy; cur_am = tbl[i].am;
            cyc();
            chk($sformatf("tbl%0d", i), 16'({bus.datout, bus.busy_out, bus.addr_match_out}),
                16'({tbl[i].exp_dout, tbl[i].exp_busy, tbl[i].exp_am}));
        end
        cur_busy = 1'b0; cur_am = 1'b0; cur_strb = 1'b0;

        // Latency, 5-tick decay and read-clear flags on channel 2
        do_reset();
        wr(4'd2, 8'd5);
        wr(4'd8, 8'h04);
        idle(2);
        chk_bit("ch2_low", 2, 1'b1);
        cur_q[2] = 1'b1;
        cyc(); chk_bit("lat_clk1", 2, 1'b1);
        cyc(); chk_bit("lat_clk2", 2, 1'b1);
        cyc(); chk_bit("lat_clk3", 2, 1'b0);
        cyc();
        cur_q[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pulse();
            chk_bit($sformatf("decay5_tick%0d", k), 2, (k == 5));
        end
        rd(4'd9, 8'h04, "flags_first");
        rd(4'd9, 8'h00, "flags_cleared");

        // Zero decay keeps the line low
        do_reset();
        wr(4'd0, 8'd0);
        wr(4'd8, 8'h01);
        idle(2);
        edge_on(0, 4);
        pulse();
        chk_bit("d0_stays_low", 0, 1'b1);
        rd(4'd9, 8'h01, "d0_flag");

        // Retrigger after 6 ticks restarts the full 10-tick decay
        do_reset();
        wr(4'd1, 8'd10);
        wr(4'd8, 8'h02);
        idle(2);
        edge_on(1, 2);
        repeat (6) pulse();
        chk_bit("retrig_mid", 1, 1'b0);
        edge_on(1, 2);
        for (int k = 1; k <= 10; k++) begin
            pulse();
            chk_bit($sformatf("retrig_tick%0d", k), 1, (k == 10));
        end

        // Disable mid-decay, new decay value used only at the next trigger
        do_reset();
        wr(4'd3, 8'd20);
        wr(4'd8, 8'h08);
        idle(2);
        edge_on(3, 2);
        repeat (2) pulse();
        wr(4'd3, 8'd3);
        wr(4'd8, 8'h00);
        idle(2);
        chk_bit("disabled", 3, 1'b0);
        repeat (25) pulse();
        chk_bit("stays_off", 3, 1'b0);
        wr(4'd8, 8'h08);
        idle(2);
        chk_bit("reenabled", 3, 1'b1);
        edge_on(3, 2);
        for (int k = 1; k <= 3; k++) begin
            pulse();
            chk_bit($sformatf("newd_tick%0d", k), 3, (k == 3));
        end

        // Reset in the middle of a 50-tick decay
        do_reset();
        wr(4'd4, 8'd50);
        wr(4'd8, 8'h30);
        idle(2);
        edge_on(4, 2);
        repeat (20) pulse();
        chk_bit("pre_rst_ch4", 4, 1'b0);
        chk_bit("pre_rst_ch5", 5, 1'b1);
        do_reset();
        for (int i = 0; i <= 10; i++) rd(4'(i), 8'h00, $sformatf("post_rst_reg%0d", i));
        edge_on(4, 2);
        repeat (3) pulse();
        chk("post_rst_q_oe", 16'(q_oe), 16'h0000);
        rd(4'd9, 8'h00, "post_rst_flags");

        // Channel-0 edge counter wraps 255 -> 0
        do_reset();
        rd(4'd10, 8'h00, "cnt_start");
        for (int i = 0; i < 257; i++) begin
            cur_q[0] = 1'b1; cyc();
            cur_q[0] = 1'b0; cyc();
        end
        idle(3);
        rd(4'd10, c_EXP_CNT257, "cnt_257");
        rd(4'd10, 8'h00, "cnt_reread");

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cur_q    = cur_q ^ 8'($urandom & $urandom);
            cur_u    = ($urandom_range(0, 4) == 0);
            cur_strb = ($urandom_range(0, 2) == 0);
            cur_rw   = 1'($urandom_range(0, 1));
            cur_busy = 1'($urandom_range(0, 1));
            cur_am   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) cur_addr = 12'($urandom);
            else cur_addr = c_BASE | 12'($urandom_range(0, 11));
            if (cur_addr[3:0] < 4'd8) cur_din = 8'($urandom_range(0, 6));
            else cur_din = 8'($urandom);
            cyc();
        end
        cur_strb = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
